// File: rtl/qdr_dly_sequencer_if.sv
// rtl/qdr_dly_sequencer_if.sv - command handshake and IODELAY line bundle for the QDR tap sequencer
interface qdr_dly_sequencer_if #(
  parameter int N_IN  = 36,
  parameter int N_OUT = 37,
  parameter int TAP_W = 5
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [1:0]                    cmd_op;
  logic                          cmd_bank;
  logic [5:0]                    cmd_bit;
  logic                          cmd_dir;
  logic [5:0]                    cmd_count;
  logic                          busy;
  logic                          done;
  logic                          sat;
  logic                          err;
  logic [N_IN-1:0]               dly_en_i;
  logic [N_OUT-1:0]              dly_en_o;
  logic                          dly_inc_dec;
  logic [TAP_W*(N_IN+N_OUT)-1:0] dly_cntrs;

  modport master (
    output cmd_valid, cmd_op, cmd_bank, cmd_bit, cmd_dir, cmd_count,
    input  cmd_ready, busy, done, sat, err, dly_en_i, dly_en_o, dly_inc_dec, dly_cntrs
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_bank, cmd_bit, cmd_dir, cmd_count,
    output cmd_ready, busy, done, sat, err, dly_en_i, dly_en_o, dly_inc_dec, dly_cntrs
  );
endinterface

// File: rtl/qdr_dly_sequencer.sv
// rtl/qdr_dly_sequencer.sv - QDR IODELAY tap sequencer: spaced inc/dec pulses with shadow tap counters
module qdr_dly_sequencer #(
  parameter int N_IN  = 36,
  parameter int N_OUT = 37,
  parameter int TAP_W = 5,
  parameter int GAP   = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  qdr_dly_sequencer_if.slave bus
);
  localparam int N_TOT = N_IN + N_OUT;
  localparam int LIN_W = $clog2(N_IN + 64);

  localparam logic [TAP_W-1:0] TAP_MAX     = '1;
  localparam logic [5:0]       BIT_LIM_IN  = 6'(N_IN);
  localparam logic [5:0]       BIT_LIM_OUT = 6'(N_OUT);
  localparam logic [5:0]       SET_LIM     = 6'(TAP_MAX);
  localparam logic [LIN_W-1:0] LIN_OUT0    = LIN_W'(N_IN);
  localparam logic [LIN_W-1:0] LIN_END     = LIN_W'(N_TOT);
  localparam logic [3:0]       GAP_LAST    = 4'(GAP - 1);

  localparam logic [1:0] OP_STEP = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_ZERO = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             bank_q, bank_d;
  logic [5:0]       bit_q, bit_d;
  logic             dir_q, dir_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [LIN_W-1:0] lin_q, lin_d;
  logic [3:0]       gap_q, gap_d;
  logic             inc_dec_q, inc_dec_d;
  logic             sat_q, sat_d;
  logic             err_q, err_d;
  logic [TAP_W-1:0] tap_q [N_TOT];

  logic [TAP_W-1:0] cur_tap;
  logic [N_TOT-1:0] en_all;
  logic             ready;
  logic             reject;
  logic             at_limit;

  // lin_q is a flat line number: inputs first, outputs from N_IN upward
  always_comb begin
    cur_tap = '0;
    for (int l = 0; l < N_TOT; l++) begin
      if (lin_q == LIN_W'(l)) begin
        cur_tap = tap_q[l];
      end
    end
  end

  assign ready    = (state_q == S_IDLE) && !rst_i;
  assign reject   = (!bank_q && (bit_q >= BIT_LIM_IN)) ||
                    (bank_q && (bit_q >= BIT_LIM_OUT)) ||
                    (op_q == OP_RSVD) ||
                    ((op_q == OP_SET) && (cnt_q > SET_LIM));
  assign at_limit = dir_q ? (cur_tap == TAP_MAX) : (cur_tap == '0);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    bank_d    = bank_q;
    bit_d     = bit_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    lin_d     = lin_q;
    gap_d     = gap_q;
    inc_dec_d = inc_dec_q;
    sat_d     = sat_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && ready) begin
          op_d    = bus.cmd_op;
          bank_d  = bus.cmd_bank;
          bit_d   = bus.cmd_bit;
          dir_d   = bus.cmd_dir;
          cnt_d   = bus.cmd_count;
          sat_d   = 1'b0;
          err_d   = 1'b0;
          if (bus.cmd_op == OP_ZERO) begin
            lin_d = '0;
          end else if (bus.cmd_bank) begin
            lin_d = LIN_OUT0 + LIN_W'(bus.cmd_bit);
          end else begin
            lin_d = LIN_W'(bus.cmd_bit);
          end
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (reject) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          unique case (op_q)
            OP_STEP: begin
              if (cnt_q == '0) begin
                state_d = S_DONE;
              end else if (at_limit) begin
                sat_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                inc_dec_d = dir_q;
                state_d   = S_SETUP;
              end
            end
            OP_SET: begin
              if (6'(cur_tap) == cnt_q) begin
                state_d = S_DONE;
              end else begin
                inc_dec_d = (6'(cur_tap) < cnt_q);
                state_d   = S_SETUP;
              end
            end
            default: begin
              // ZERO_ALL walks every line, spending one CHECK cycle on lines already at zero
              if (lin_q >= LIN_END) begin
                state_d = S_DONE;
              end else if (cur_tap == '0) begin
                lin_d = lin_q + 1'b1;
              end else begin
                inc_dec_d = 1'b0;
                state_d   = S_SETUP;
              end
            end
          endcase
        end
      end

      S_SETUP: state_d = S_PULSE;

      S_PULSE: begin
        gap_d   = GAP_LAST;
        state_d = S_GAP;
        if (op_q == OP_STEP) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_CHECK;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      bank_q    <= 1'b0;
      bit_q     <= '0;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      lin_q     <= '0;
      gap_q     <= '0;
      inc_dec_q <= 1'b0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
      for (int l = 0; l < N_TOT; l++) begin
        tap_q[l] <= '0;
      end
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      bank_q    <= bank_d;
      bit_q     <= bit_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      lin_q     <= lin_d;
      gap_q     <= gap_d;
      inc_dec_q <= inc_dec_d;
      sat_q     <= sat_d;
      err_q     <= err_d;
      // CHECK has already guaranteed the pulsed line stays inside 0..TAP_MAX
      if (state_q == S_PULSE) begin
        for (int l = 0; l < N_TOT; l++) begin
          if (lin_q == LIN_W'(l)) begin
            tap_q[l] <= inc_dec_q ? tap_q[l] + 1'b1 : tap_q[l] - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    en_all = '0;
    if (state_q == S_PULSE) begin
      for (int l = 0; l < N_TOT; l++) begin
        if (lin_q == LIN_W'(l)) begin
          en_all[l] = 1'b1;
        end
      end
    end
  end

  assign bus.cmd_ready   = ready;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.sat         = sat_q;
  assign bus.err         = err_q;
  assign bus.dly_inc_dec = inc_dec_q;
  assign bus.dly_en_i    = en_all[N_IN-1:0];
  assign bus.dly_en_o    = en_all[N_TOT-1:N_IN];

  for (genvar g = 0; g < N_TOT; g++) begin : g_pack
    assign bus.dly_cntrs[TAP_W*g +: TAP_W] = tap_q[g];
  end
endmodule

// File: doc/qdr_dly_sequencer.md
# qdr_dly_sequencer

Command-driven sequencer for the QDR IODELAY tap adjustment lines. It accepts step, set-absolute and zero-all commands through a valid/ready handshake. It issues correctly spaced single-cycle enable pulses on the 36 input-delay and 37 output-delay lines, with `dly_inc_dec` set up one cycle ahead of each pulse. It keeps a 5-bit shadow tap counter per line, and software reads those counters through the QDR config register block. The block sits in the `dly_clk` domain between the config/calibration logic and the QDR PHY IODELAY primitives.

## Interface
- `N_IN`, 36: input-delay lines (D bits).
- `N_OUT`, 37: output-delay lines (Q/addr/ctrl).
- `TAP_W`, 5: tap counter width; the tap range is 0..31.
- `GAP`, 3: idle cycles after each pulse, valid range 1..15.
- `clk`  in  1: the delay clock (`dly_clk`). It is the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command request.
- `cmd_ready`  out  1: high only in IDLE.
- `cmd_op`  in  2: command opcode.
  - 00: STEP.
  - 01: SET.
  - 10: ZERO_ALL.
  - 11: reserved; treated as an error.
- `cmd_bank`  in  1: 0 selects the input bank, 1 selects the output bank.
- `cmd_bit`  in  6: line index within the selected bank.
- `cmd_dir`  in  1: STEP direction; 1 increments, 0 decrements.
- `cmd_count`  in  6: STEP pulse count (0..63), or SET target tap (0..31).
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `done`  out  1: one-cycle pulse at command completion.
- `sat`  out  1: a STEP stopped early at tap 0 or tap 31.
- `err`  out  1: the command was rejected; no pulses were issued.
- `dly_en_i`  out  `N_IN`: input-line enable pulses.
- `dly_en_o`  out  `N_OUT`: output-line enable pulses.
- `dly_inc_dec`  out  1: direction for the current pulse; 1 increments.
- `dly_cntrs`  out  `TAP_W*(N_IN+N_OUT)`: packed shadow tap counters.
  - Input line k occupies `[TAP_W*k +: TAP_W]`.
  - Output line j occupies `[TAP_W*(N_IN+j) +: TAP_W]`.

## Operation
- **FSM states:** IDLE, CHECK, SETUP, PULSE, GAP, DONE.
- **Accept:** a command is accepted when `cmd_valid && cmd_ready`.
  - Accept latches all `cmd_*` fields and clears `sat` and `err`.
  - The FSM then moves IDLE→CHECK.
  - For ZERO_ALL, accept also sets the line index to 0.
- **Validation (first CHECK):** the command is rejected if any of the following holds.
  - `cmd_bit >= N_IN` with bank 0.
  - `cmd_bit >= N_OUT` with bank 1.
  - `cmd_op` = 11.
  - SET with `cmd_count > 31`.
  - On rejection: `err` = 1 and the FSM goes to DONE. No line is pulsed and no counter changes.
- **STEP in CHECK:**
  - Remaining count = 0: go to DONE.
  - Counter at the limit for the direction (31 for increment, 0 for decrement): set `sat` = 1 and go to DONE.
  - Otherwise: go to SETUP.
- **SET in CHECK:**
  - Counter equals the target: go to DONE.
  - Counter below the target: increment direction, go to SETUP.
  - Counter above the target: decrement direction, go to SETUP.
  - SET never sets `sat`.
- **ZERO_ALL in CHECK:**
  - Index > 72: go to DONE.
  - Counter[index] = 0: increment the index and stay in CHECK.
  - Otherwise: decrement direction, go to SETUP.
  - Index 0..35 addresses the input lines; index 36..72 addresses the output lines.
- **SETUP:** drives `dly_inc_dec` for the pulse that follows.
- **PULSE:** exactly one bit of `dly_en_i`/`dly_en_o` is high, for one cycle. In the same cycle:
  - the shadow counter moves by ±1, visible on the next cycle;
  - the STEP remaining count decrements.
- **GAP:** lasts `GAP` cycles with all enables low, then returns to CHECK.
- **DONE:** `done` = 1 for one cycle, then IDLE.
- **Counter arithmetic:** counters never wrap. A pulse is never issued when it would take a counter outside 0..31.
- **`dly_inc_dec` stability:** it changes only in SETUP and holds through PULSE, GAP and IDLE.
- **Status flags:** `sat` and `err` stay valid from DONE until the next accept.

## Timing
- **Reset values:** all outputs 0 and all counters 0. In the first cycle after `rst` falls, `cmd_ready` = 1.
- **Pulse period:** 3+`GAP` cycles (CHECK, SETUP, PULSE, then `GAP` cycles of GAP).
- **STEP with N pulses and no saturation**, with accept at cycle 0:
  - pulse k (1-based) falls at cycle 3+(k−1)(3+`GAP`);
  - `done` is high at cycle 2+N(3+`GAP`);
  - `cmd_ready` is high at cycle 3+N(3+`GAP`).
- **Zero-latency completion:** a STEP with N = 0, a rejected command, or a SET already at its target gives `done` at cycle 2.
- **ZERO_ALL:** takes one cycle per line already at zero, plus 3+`GAP` cycles per pulse.
- **Commands while busy:** `cmd_valid` is ignored while `busy`. A request still held is accepted in the first IDLE cycle.
- **Reset mid-command:** `rst` at any cycle returns the FSM to IDLE at that edge. At the same edge, enables, `dly_inc_dec`, counters and flags are cleared. The IODELAYs share the same reset, so counters stay consistent with them.

## Test plan
- **STEP increment:** reset, then STEP bank0 bit5 inc count=4 (`GAP`=3) → `dly_en_i[5]` pulses at cycles 3, 9, 15 and 21; `dly_inc_dec` = 1 from cycle 2; `done` at cycle 26; counter5 = 4.
- **STEP saturation:** STEP bank1 bit36 inc count=40 → 31 pulses on `dly_en_o[36]`; `sat` = 1; counter = 31; then STEP dec count=2 → counter = 29, `sat` = 0.
- **SET both directions:** SET bank0 bit0 target 7 from 0 → 7 increment pulses; then SET target 3 → 4 pulses with `dly_inc_dec` = 0; counter = 3.
- **Rejected commands:** bank0 bit36, bank1 bit37, op=11, and SET with count 40 → each gives `err` = 1, `done` at cycle 2, no enable pulses, counters unchanged.
- **ZERO_ALL:** with counters in0 = 2, out5 = 1 and all others 0 → exactly 3 decrement pulses (`dly_en_i[0]` twice, then `dly_en_o[5]`); all counters 0; `done` once.
- **Reset and busy handling:**
  - Assert `rst` during the GAP after the 2nd pulse of a count=10 STEP → next cycle all outputs are 0 and `cmd_ready` = 1.
  - Hold `cmd_valid` throughout → the held command is accepted only in IDLE.
